// File: rtl/time_entry_encoder_if.sv
// Keypad-to-counter handshake bundle for time_entry_encoder.
// master drives keypad strobes and observes results; slave is the encoder.
interface time_entry_encoder_if;
   logic [3:0]  digit_in;
   logic        digit_valid;
   logic        enter;
   logic        clear;
   logic [15:0] entry_bcd;
   logic [2:0]  digit_count;
   logic [11:0] load_value;
   logic        load_strobe;
   logic        error;
   logic        busy;

   modport master (
      output digit_in, digit_valid, enter, clear,
      input  entry_bcd, digit_count, load_value, load_strobe, error, busy
   );

   modport slave (
      input  digit_in, digit_valid, enter, clear,
      output entry_bcd, digit_count, load_value, load_strobe, error, busy
   );
endinterface

// File: rtl/time_entry_encoder.sv
// Builds an M1M0:S1S0 BCD entry from keypad digits, range-checks it and emits a
// packed {min,sec} load word. Optional macro SEC_NORMALIZE_EN folds sec 60..99 into min.
module time_entry_encoder #(
   parameter int MAX_MIN = 59
) (
   input  logic                 clk,
   input  logic                 nrst,
   time_entry_encoder_if.slave  bus
);

   typedef enum logic [2:0] {S_IDLE, S_ENTRY, S_CHECK, S_LOAD, S_ERR} state_t;

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_entry;
   logic [2:0]  r_count;
   logic [11:0] r_load_value;

   logic        w_digit_ok;
   logic [6:0]  w_sec_raw;
   logic [6:0]  w_min_raw;
   logic [6:0]  w_sec;
   logic [6:0]  w_min;
   logic        w_in_range;

   assign w_digit_ok = bus.digit_valid && (bus.digit_in <= 4'd9);

   // Range check uses full 7-bit values; truncation to 6 bits happens only on load.
   always_comb begin
      w_sec_raw = {3'b0, r_entry[7:4]}   * 7'd10 + {3'b0, r_entry[3:0]};
      w_min_raw = {3'b0, r_entry[15:12]} * 7'd10 + {3'b0, r_entry[11:8]};
      w_sec     = w_sec_raw;
      w_min     = w_min_raw;
`ifdef SEC_NORMALIZE_EN
      if (w_sec_raw >= 7'd60) begin
         w_sec = w_sec_raw - 7'd60;
         w_min = w_min_raw + 7'd1;
      end
`endif
      w_in_range = (w_min <= 7'(MAX_MIN)) && (w_sec <= 7'd59);
   end

   always_ff @(posedge clk) begin
      if (!nrst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (!bus.clear && w_digit_ok) w_next = S_ENTRY;
         S_ENTRY: begin
            if      (bus.clear) w_next = S_IDLE;
            else if (bus.enter) w_next = S_CHECK;
         end
         S_CHECK: w_next = w_in_range ? S_LOAD : S_ERR;
         S_LOAD:  w_next = S_IDLE;
         S_ERR: begin
            if      (bus.clear) w_next = S_IDLE;
            else if (w_digit_ok) w_next = S_ENTRY;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Entry shift register, digit counter and held load word.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_entry      <= '0;
         r_count      <= '0;
         r_load_value <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!bus.clear && w_digit_ok) begin
                  r_entry <= {12'h000, bus.digit_in};
                  r_count <= 3'd1;
               end
            end
            S_ENTRY: begin
               if (bus.clear) begin
                  r_entry <= '0;
                  r_count <= '0;
               end else if (!bus.enter && w_digit_ok) begin
                  r_entry <= {r_entry[11:0], bus.digit_in};
                  r_count <= (r_count == 3'd4) ? 3'd4 : r_count + 3'd1;
               end
            end
            S_CHECK: begin
               if (w_in_range) r_load_value <= {w_min[5:0], w_sec[5:0]};
            end
            S_LOAD: begin
               r_entry <= '0;
               r_count <= '0;
            end
            S_ERR: begin
               if (bus.clear) begin
                  r_entry <= '0;
                  r_count <= '0;
               end else if (w_digit_ok) begin
                  r_entry <= {12'h000, bus.digit_in};
                  r_count <= 3'd1;
               end
            end
            default: begin
               r_entry <= '0;
               r_count <= '0;
            end
         endcase
      end
   end

   always_comb begin
      bus.entry_bcd   = r_entry;
      bus.digit_count = r_count;
      bus.load_value  = r_load_value;
      bus.load_strobe = (r_state == S_LOAD);
      bus.error       = (r_state == S_ERR);
      bus.busy        = (r_state == S_CHECK) || (r_state == S_LOAD);
   end

endmodule

// File: tb/tb_time_entry_encoder.sv
// Self-checking bench: directed vector table for the corner cases, then random
// keypad traffic compared against a decimal-arithmetic reference model.
module tb_time_entry_encoder;

   logic clk;
   logic nrst;
   time_entry_encoder_if bus ();

   time_entry_encoder #(.MAX_MIN(59)) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit        rst;
      bit        dv;
      bit [3:0]  d;
      bit        en;
      bit        clr;
      bit [15:0] e_ent;
      bit [2:0]  e_cnt;
      bit        e_stb;
      bit [11:0] e_lv;
      bit        e_err;
      bit        e_busy;
   } vec_t;

   vec_t tbl[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Reference model state: phase of a commit, typed digits, last loaded word.
   localparam int M_IDLE = 0, M_ENTRY = 1, M_CHECK = 2, M_LOAD = 3, M_ERR = 4;
   int m_mode;
   int digs[$];
   int m_lv;

   function automatic void add(bit rst, bit dv, bit [3:0] d, bit en, bit clr,
                               bit [15:0] ent, bit [2:0] cnt, bit stb,
                               bit [11:0] lv, bit err, bit busy);
      vec_t v;
      v.rst = rst; v.dv = dv; v.d = d; v.en = en; v.clr = clr;
      v.e_ent = ent; v.e_cnt = cnt; v.e_stb = stb; v.e_lv = lv;
      v.e_err = err; v.e_busy = busy;
      tbl.push_back(v);
   endfunction

   function automatic void model_step(bit rst, bit dv, int d, bit en, bit clr);
      bit ok;
      int n, mn, sc;
      ok = dv && (d <= 9);
      if (rst) begin
         m_mode = M_IDLE; digs.delete(); m_lv = 0;
         return;
      end
      case (m_mode)
         M_IDLE: if (!clr && ok) begin digs = {d}; m_mode = M_ENTRY; end
         M_ENTRY: begin
            if (clr) begin digs.delete(); m_mode = M_IDLE; end
            else if (en) m_mode = M_CHECK;
            else if (ok) begin
               digs.push_back(d);
               if (digs.size() > 4) void'(digs.pop_front());
            end
         end
         M_CHECK: begin
            n = 0;
            foreach (digs[i]) n = n * 10 + digs[i];
            mn = n / 100;
            sc = n % 100;
`ifdef SEC_NORMALIZE_EN
            if (sc >= 60) begin mn = mn + 1; sc = sc - 60; end
`endif
            if (mn <= 59 && sc <= 59) begin
               m_lv = mn * 64 + sc;
               m_mode = M_LOAD;
            end else m_mode = M_ERR;
         end
         M_LOAD: begin digs.delete(); m_mode = M_IDLE; end
         M_ERR: begin
            if (clr) begin digs.delete(); m_mode = M_IDLE; end
            else if (ok) begin digs = {d}; m_mode = M_ENTRY; end
         end
         default: m_mode = M_IDLE;
      endcase
   endfunction

   function automatic int model_entry();
      int e;
      e = 0;
      foreach (digs[i]) e = e * 16 + digs[i];
      return e;
   endfunction

   task automatic drive(bit rst, bit dv, bit [3:0] d, bit en, bit clr);
      nrst            = !rst;
      bus.digit_valid = dv;
      bus.digit_in    = d;
      bus.enter       = en;
      bus.clear       = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic check(string tag, int idx, bit [15:0] ee, bit [2:0] ec, bit es,
                        bit [11:0] el, bit eer, bit eb);
      n_vec++;
      if ({bus.entry_bcd, bus.digit_count, bus.load_strobe, bus.load_value, bus.error, bus.busy}
          !== {ee, ec, es, el, eer, eb}) begin
         n_err++;
         $display("FAIL %s[%0d] got ent=%h cnt=%0d stb=%b lv=%h err=%b busy=%b | exp ent=%h cnt=%0d stb=%b lv=%h err=%b busy=%b",
                  tag, idx, bus.entry_bcd, bus.digit_count, bus.load_strobe, bus.load_value,
                  bus.error, bus.busy, ee, ec, es, el, eer, eb);
      end
   endtask

   initial begin
      bit [11:0] lv3;
      nrst = 1'b0;
      bus.digit_valid = 1'b0; bus.digit_in = 4'h0; bus.enter = 1'b0; bus.clear = 1'b0;

      // reset
      add(1,0,0,0,0, 'h0000,0,0,'h000,0,0);
      // 12:30 commit
      add(0,1,1,0,0, 'h0001,1,0,'h000,0,0);
      add(0,1,2,0,0, 'h0012,2,0,'h000,0,0);
      add(0,1,3,0,0, 'h0123,3,0,'h000,0,0);
      add(0,1,0,0,0, 'h1230,4,0,'h000,0,0);
      add(0,0,0,1,0, 'h1230,4,0,'h000,0,1);
      add(0,0,0,0,0, 'h1230,4,1,'h31E,0,1);
      add(0,0,0,0,0, 'h0000,0,0,'h31E,0,0);
      // 0:45 commit, then saturation at four digits
      add(0,1,4,0,0, 'h0004,1,0,'h31E,0,0);
      add(0,1,5,0,0, 'h0045,2,0,'h31E,0,0);
      add(0,0,0,1,0, 'h0045,2,0,'h31E,0,1);
      add(0,0,0,0,0, 'h0045,2,1,'h02D,0,1);
      add(0,0,0,0,0, 'h0000,0,0,'h02D,0,0);
      add(0,1,9,0,0, 'h0009,1,0,'h02D,0,0);
      add(0,1,9,0,0, 'h0099,2,0,'h02D,0,0);
      add(0,1,9,0,0, 'h0999,3,0,'h02D,0,0);
      add(0,1,9,0,0, 'h9999,4,0,'h02D,0,0);
      add(0,1,1,0,0, 'h9991,4,0,'h02D,0,0);
      add(0,0,0,0,1, 'h0000,0,0,'h02D,0,0);
      // 01:75 seconds out of range (or normalized to 2:15)
      add(0,1,0,0,0, 'h0000,1,0,'h02D,0,0);
      add(0,1,1,0,0, 'h0001,2,0,'h02D,0,0);
      add(0,1,7,0,0, 'h0017,3,0,'h02D,0,0);
      add(0,1,5,0,0, 'h0175,4,0,'h02D,0,0);
      add(0,0,0,1,0, 'h0175,4,0,'h02D,0,1);
`ifdef SEC_NORMALIZE_EN
      lv3 = 12'h08F;
      add(0,0,0,0,0, 'h0175,4,1,lv3,0,1);
      add(0,0,0,0,0, 'h0000,0,0,lv3,0,0);
      add(0,0,0,1,0, 'h0000,0,0,lv3,0,0);
`else
      lv3 = 12'h02D;
      add(0,0,0,0,0, 'h0175,4,0,lv3,1,0);
      add(0,0,0,0,0, 'h0175,4,0,lv3,1,0);
      add(0,0,0,1,0, 'h0175,4,0,lv3,1,0);
`endif
      add(0,1,3,0,0, 'h0003,1,0,lv3,0,0);
      add(0,0,0,0,1, 'h0000,0,0,lv3,0,0);
      // 60:00 minute out of range, then clear
      add(0,1,6,0,0, 'h0006,1,0,lv3,0,0);
      add(0,1,0,0,0, 'h0060,2,0,lv3,0,0);
      add(0,1,0,0,0, 'h0600,3,0,lv3,0,0);
      add(0,1,0,0,0, 'h6000,4,0,lv3,0,0);
      add(0,0,0,1,0, 'h6000,4,0,lv3,0,1);
      add(0,0,0,0,0, 'h6000,4,0,lv3,1,0);
      add(0,0,0,0,1, 'h0000,0,0,lv3,0,0);
      // digit with enter is dropped; non-BCD digit ignored; enter in IDLE
      add(0,1,1,0,0, 'h0001,1,0,lv3,0,0);
      add(0,1,2,0,0, 'h0012,2,0,lv3,0,0);
      add(0,1,5,1,0, 'h0012,2,0,lv3,0,1);
      add(0,0,0,0,0, 'h0012,2,1,'h00C,0,1);
      add(0,0,0,0,0, 'h0000,0,0,'h00C,0,0);
      add(0,1,7,0,0, 'h0007,1,0,'h00C,0,0);
      add(0,1,'hB,0,0, 'h0007,1,0,'h00C,0,0);
      add(0,0,0,0,1, 'h0000,0,0,'h00C,0,0);
      add(0,0,0,1,0, 'h0000,0,0,'h00C,0,0);
      // reset during CHECK aborts the commit
      add(0,1,2,0,0, 'h0002,1,0,'h00C,0,0);
      add(0,1,0,0,0, 'h0020,2,0,'h00C,0,0);
      add(0,1,0,0,0, 'h0200,3,0,'h00C,0,0);
      add(0,1,0,0,0, 'h2000,4,0,'h00C,0,0);
      add(0,0,0,1,0, 'h2000,4,0,'h00C,0,1);
      add(1,0,0,0,0, 'h0000,0,0,'h000,0,0);
      add(0,0,0,0,0, 'h0000,0,0,'h000,0,0);
      // strobes while busy are ignored
      add(0,1,3,0,0, 'h0003,1,0,'h000,0,0);
      add(0,1,4,0,0, 'h0034,2,0,'h000,0,0);
      add(0,0,0,1,0, 'h0034,2,0,'h000,0,1);
      add(0,1,7,1,1, 'h0034,2,1,'h022,0,1);
      add(0,1,8,0,1, 'h0000,0,0,'h022,0,0);
      add(0,0,0,0,0, 'h0000,0,0,'h022,0,0);

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].dv, tbl[i].d, tbl[i].en, tbl[i].clr);
         check("dir", i, tbl[i].e_ent, tbl[i].e_cnt, tbl[i].e_stb, tbl[i].e_lv,
               tbl[i].e_err, tbl[i].e_busy);
      end

      // random keypad traffic against the reference model
      model_step(1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      for (int k = 0; k < 3000; k++) begin
         int r, d;
         bit rst, dv, en, clr;
         r = $urandom_range(0, 99);
         d = $urandom_range(0, 11);
         rst = (r < 2);
         dv  = (r >= 2  && r < 52);
         en  = (r >= 52 && r < 67);
         clr = (r >= 67 && r < 75);
         model_step(rst, dv, d, en, clr);
         drive(rst, dv, 4'(d), en, clr);
         check("rnd", k, 16'(model_entry()), 3'(digs.size()), m_mode == M_LOAD,
               12'(m_lv), m_mode == M_ERR, (m_mode == M_CHECK) || (m_mode == M_LOAD));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
